// File: rtl/pwm_peripheral.sv
// 16-channel PWM generator with one shared duty value that only takes effect at period boundaries.
// Each channel can be forced off, forced on, or follow the shared PWM waveform.

module pwm_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic en_out,
  input  logic en_pwm,
  input  logic pwm_sig,
  output logic out
);

  always_ff @(posedge clk) begin
    if (!rst_n) out <= 1'b0;
    else        out <= en_out & (en_pwm ? pwm_sig : 1'b1);
  end

endmodule

module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]     p;
  logic [7:0]        c;
  logic [7:0]        duty_shadow;
  logic [7:0]        d;
  logic              tick;
  logic              ps_cycle;
  logic              pwm_sig;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;

  assign tick     = (p == P_MAX);
  assign ps_cycle = (p == '0) && (c == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p            <= '0;
      c            <= 8'd0;
      duty_shadow  <= 8'd0;
      period_start <= 1'b0;
    end else begin
      p            <= tick ? '0 : p + 1'b1;
      if (tick) c  <= c + 8'd1;
      if (ps_cycle) duty_shadow <= pwm_duty_cycle;
      period_start <= ps_cycle;
    end
  end

  // The live input is used on the period-start cycle itself so a new duty
  // covers the whole period, including its very first clock.
  assign d       = ps_cycle ? pwm_duty_cycle : duty_shadow;
  assign pwm_sig = (d == 8'd255) || (c < d);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_lane
      pwm_lane u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_out  (en_out[i]),
        .en_pwm  (en_pwm[i]),
        .pwm_sig (pwm_sig),
        .out     (out[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench: PRESCALE=13 instance for duty/enable/reset scenarios, PRESCALE=1 instance for the fast case.

module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_b;
  logic [15:0] en_out, en_pwm, en_out_b, en_pwm_b;
  logic [7:0]  duty, duty_b;
  logic [15:0] out, out_b;
  logic        period_start, period_start_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty), .out(out), .period_start(period_start)
  );

  pwm_peripheral #(.PRESCALE(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .en_reg_out_7_0(en_out_b[7:0]), .en_reg_out_15_8(en_out_b[15:8]),
    .en_reg_pwm_7_0(en_pwm_b[7:0]), .en_reg_pwm_15_8(en_pwm_b[15:8]),
    .pwm_duty_cycle(duty_b), .out(out_b), .period_start(period_start_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples n cycles of the PRESCALE=13 instance, tracking out[1] as the PWM
  // reference and flagging any sample that is neither hi_pat nor lo_pat.
  task automatic measure(input int n, input logic [15:0] hi_pat, input logic [15:0] lo_pat,
                         output int hi, output int bad, output int ps_cnt,
                         output int ps_first, output int first_low);
    hi = 0; bad = 0; ps_cnt = 0; ps_first = 0; first_low = -1;
    for (int k = 0; k < n; k++) begin
      step();
      if (out[1]) hi++;
      else if (first_low < 0) first_low = k;
      if (out !== (out[1] ? hi_pat : lo_pat)) bad++;
      if (period_start) begin
        ps_cnt++;
        if (k == 0) ps_first = 1;
      end
    end
  endtask

  initial begin
    int hi, bad, ps_cnt, ps_first, first_low, hi2;

    rst_n = 1'b0; rst_n_b = 1'b0;
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'd128;
    en_out_b = 16'h0001; en_pwm_b = 16'h0001; duty_b = 8'd3;
    repeat (3) step();
    check("reset_out", out, 0);
    check("reset_ps", period_start, 0);

    // duty 128 from reset: 1664 high, 1664 low, period 3328
    rst_n = 1'b1;
    measure(3328, 16'hFFFF, 16'h0000, hi, bad, ps_cnt, ps_first, first_low);
    check("d128_hi", hi, 1664);
    check("d128_first_low", first_low, 1664);
    check("d128_uniform", bad, 0);
    check("d128_ps_cnt", ps_cnt, 1);
    check("d128_ps_first", ps_first, 1);

    duty = 8'd0;
    measure(3328, 16'hFFFF, 16'h0000, hi, bad, ps_cnt, ps_first, first_low);
    check("d0_hi", hi, 0);
    check("d0_ps_first", ps_first, 1);
    check("d0_ps_cnt", ps_cnt, 1);

    duty = 8'd255;
    measure(3328, 16'hFFFF, 16'h0000, hi, bad, ps_cnt, ps_first, first_low);
    check("d255_hi", hi, 3328);
    check("d255_uniform", bad, 0);

    // mid-period change at c==100 must not disturb the running period
    duty = 8'd64;
    measure(1300, 16'hFFFF, 16'h0000, hi, bad, ps_cnt, ps_first, first_low);
    duty = 8'd192;
    measure(2028, 16'hFFFF, 16'h0000, hi2, bad, ps_cnt, ps_first, first_low);
    check("mid_cur_hi", hi + hi2, 832);
    check("mid_tail_hi", hi2, 0);
    measure(3328, 16'hFFFF, 16'h0000, hi, bad, ps_cnt, ps_first, first_low);
    check("mid_next_hi", hi, 2496);
    check("mid_next_first_low", first_low, 2496);

    // mixed enables: [3:0] PWM, [7:4] forced on, [15:8] off
    duty = 8'd64; en_out = 16'h00FF; en_pwm = 16'h000F;
    measure(3328, 16'h00FF, 16'h00F0, hi, bad, ps_cnt, ps_first, first_low);
    check("mix_hi", hi, 832);
    check("mix_pattern", bad, 0);
    step();
    check("mix_start", out, 16'h00FF);
    en_out = 16'h00FE;
    step();
    check("mix_en0_clear", out, 16'h00FE);

    // reset pulse at c==200 (relative cycle 2600 of this period)
    repeat (2598) step();
    rst_n = 1'b0;
    step();
    check("mid_rst_out", out, 0);
    check("mid_rst_ps", period_start, 0);
    rst_n = 1'b1;
    step();
    check("rel_ps", period_start, 1);
    check("rel_out", out, 16'h00FE);
    measure(3327, 16'h00FE, 16'h00F0, hi, bad, ps_cnt, ps_first, first_low);
    check("rel_hi", hi, 831);
    check("rel_ps_cnt", ps_cnt, 0);
    step();
    check("rel_next_ps", period_start, 1);

    // PRESCALE=1, duty 3: high 3, low 253, period 256
    rst_n_b = 1'b1;
    hi = 0; bad = 0; ps_cnt = 0; first_low = -1;
    for (int k = 0; k < 256; k++) begin
      step();
      if (out_b[0]) hi++;
      else if (first_low < 0) first_low = k;
      if (out_b[15:1] !== 15'd0) bad++;
      if (period_start_b && k != 0) bad++;
      if (period_start_b) ps_cnt++;
    end
    check("p1_hi", hi, 3);
    check("p1_first_low", first_low, 3);
    check("p1_other_bits", bad, 0);
    check("p1_ps_cnt", ps_cnt, 1);
    step();
    check("p1_next_ps", period_start_b, 1);
    check("p1_next_out", out_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
